lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit of the rv32 core; the bus initiator that the memory-mapped slaves (RAM, CLINT, peripherals) respond to.
- Accepts one memory request from the execute stage and drives one transaction on the master side of the system bus.
- Aligns and byte-enables store data; extracts and sign/zero-extends load data.
- Raises misaligned-access faults. Single outstanding transaction, no buffering beyond one request.

Parameters:
TIMEOUT_CYCLES, 255, bus watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
bus  master_bus_if.master  -  system bus master side; drives breq, ttype (READ/WRITE), addr[31:0], wdata[31:0], wstrb[3:0]; samples rdata[31:0], bdone
req_valid  input  1  execute stage presents a memory op
req_ready  output  1  LSU can accept (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word (3 is illegal and treated as word)
req_unsigned  input  1  load zero-extends when 1
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-justified
resp_valid  output  1  one-cycle pulse; transaction finished
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  with resp_valid: access faulted
resp_cause  output  4  with resp_fault: 4 = load misaligned, 6 = store misaligned, 5/7 = load/store access fault (timeout)

Behaviour:
- Reset values: breq=0, ttype=READ, addr=0, wdata=0, wstrb=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, resp_cause=0, state=IDLE.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch the request.
    - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to RESP with the fault; no bus activity.
    - Otherwise: go to BUS.
  - BUS: breq=1 with addr, ttype, wdata and wstrb held stable for the whole state.
    - On the first cycle with bdone=1, capture rdata and go to RESP. bdone may be high in the first BUS cycle; the CLINT completes in one cycle.
    - breq deasserts in the cycle after bdone.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Latency: request accepted in cycle N; bus active from N+1; with bdone in N+1, resp_valid is high in N+2. Misaligned: resp_valid in N+1.
- Bus address: word-aligned, i.e. {addr[31:2],2'b00}.
- Store data replication: byte is replicated to all four lanes; half is replicated to both halves.
- Store wstrb: byte = 1<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- Load extraction: select the lane by addr[1:0], then sign- or zero-extend per req_unsigned.
- req_ready is low in BUS and RESP. req_valid in those states is ignored; the requester holds it.
- Reset mid-transaction: abort immediately; all outputs return to reset values. No response is produced.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to BUS and increments each BUS cycle without bdone.
  - On reaching TIMEOUT_CYCLES, breq drops and the LSU goes to RESP with resp_fault=1, cause 5 (load) or 7 (store), resp_rdata=0.
  - A bdone arriving in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; BUS waits indefinitely for bdone.

Decomposition:
- Shared package gets:
  - lsu_size_t enum (BYTE, HALF, WORD).
  - Cause constants CAUSE_LOAD_MISALIGNED=4, CAUSE_LOAD_ACCESS=5, CAUSE_STORE_MISALIGNED=6, CAUSE_STORE_ACCESS=7.
  - The existing READ/WRITE ttype enum, reused.
- One natural sub-module: lsu_align. It is combinational and handles wstrb/wdata lane steering, load extraction/extension and the misalignment check. The FSM stays in lsu.

Test Plan:
- Store word to 0x0200_4000 with data 0x0000_1234, bdone always 1 → breq high for exactly one cycle, addr=0x0200_4000, wstrb=4'b1111, wdata=0x0000_1234; resp_valid two cycles after acceptance, resp_fault=0.
- Load byte signed at 0x1003, rdata=0x80FF_0000 → wstrb=0, resp_rdata=0xFFFF_FF80. Same access with req_unsigned=1 → 0x0000_0080.
- Store half 0xBEEF at 0x1002 → wdata=0xBEEF_BEEF, wstrb=4'b1100. Load word with bdone delayed 3 cycles → addr/ttype stable throughout, req_ready low, single resp_valid pulse.
- Load word at 0x1001 → no breq; resp_valid next cycle, resp_fault=1, resp_cause=4. Store half at 0x1003 → cause 6.
- rst_n asserted during BUS with bdone held low → breq=0, req_ready=1 asynchronously; no resp_valid after release.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, bdone never asserted on a store → fault with cause 7 after 4 BUS cycles. Repeat with bdone on cycle 4 → normal completion, resp_fault=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit and the system bus.
//   lsu_size_t  : access size encoding used on req_size (3 behaves as WORD)
//   ttype_t     : bus transfer type (READ/WRITE), shared with the bus slaves
//   lsu_state_t : LSU control FSM encoding
//   CAUSE_*     : trap cause codes reported on resp_cause
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;

    // The bus always carries word addresses; lane selection is done by wstrb
    // on writes and by the LSU's own extraction on reads.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ----------------------------------------------------------------------------
// master_bus_if
// System bus between the LSU (master) and memory-mapped slaves.
//   breq   : master requests a transfer; held until the cycle after bdone
//   ttype  : READ / WRITE
//   addr   : word-aligned byte address
//   wdata  : write data, already steered to byte lanes
//   wstrb  : write byte enables (0 on reads)
//   rdata  : read data word from the slave
//   bdone  : slave completes the transfer this cycle
// ----------------------------------------------------------------------------
interface master_bus_if;
    import lsu_pkg::*;

    logic        breq;
    ttype_t      ttype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        bdone;

    modport master (
        output breq, ttype, addr, wdata, wstrb,
        input  rdata, bdone
    );

    modport slave (
        input  breq, ttype, addr, wdata, wstrb,
        output rdata, bdone
    );

endinterface

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Combinational lane steering for the LSU.
//   size        in  access size (0 byte, 1 half, 2/3 word)
//   addr_lo     in  byte offset within the word
//   is_unsigned in  zero-extend loads when 1
//   wdata       in  LSB-justified store data
//   rdata       in  raw bus read word
//   wstrb       out byte enables for a store of this size/offset
//   wdata_lane  out store data replicated across lanes
//   rdata_ext   out selected and extended load data
//   misaligned  out access crosses its natural alignment
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        if (size == BYTE) begin
            wstrb      = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        end else if (size == HALF) begin
            wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            misaligned = addr_lo[0];
        end else begin
            // size 2 and the illegal size 3 both behave as a word access
            misaligned = (addr_lo != 2'd0);
        end
    end

endmodule

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu
// Load/store unit: accepts one request from execute, runs one transaction on
// the system bus, returns extended load data or a fault.
//   clk, rst_n       core clock, async active-low reset
//   bus              system bus, master side
//   req_*            request from execute (accepted only while req_ready)
//   resp_*           one-cycle response pulse with data / fault / cause
// Parameter TIMEOUT_CYCLES: bus watchdog limit, active only when the macro
// LSU_BUS_TIMEOUT_EN is defined; otherwise BUS waits for bdone forever.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | req_ready high, waiting for req_valid
// ST_BUS  | breq high, bus fields held, waiting for bdone (or watchdog)
// ST_RESP | resp_valid pulse with captured data / fault
// ----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    master_bus_if.master       bus,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_fault,
    output logic [3:0]         resp_cause
);

    lsu_state_t state, state_nxt;

    logic [1:0]  lat_size;
    logic [1:0]  lat_lo;
    logic        lat_uns;
    logic [31:0] addr_q;
    ttype_t      ttype_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic [3:0]  cause_q;

    logic        accept;
    logic        timeout_hit;
    logic [1:0]  al_size;
    logic [1:0]  al_lo;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misaligned;

    assign accept = (state == ST_IDLE) && req_valid;

    // One aligner serves both phases: in IDLE it looks at the incoming
    // request (misalignment, store steering), in BUS at the latched one
    // (load extraction).
    assign al_size = (state == ST_IDLE) ? req_size       : lat_size;
    assign al_lo   = (state == ST_IDLE) ? req_addr[1:0]  : lat_lo;

    lsu_align u_align (
        .size        (al_size),
        .addr_lo     (al_lo),
        .is_unsigned (lat_uns),
        .wdata       (req_wdata),
        .rdata       (bus.rdata),
        .wstrb       (al_wstrb),
        .wdata_lane  (al_wdata),
        .rdata_ext   (al_rdata),
        .misaligned  (al_misaligned)
    );

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] to_cnt;

    // to_cnt counts completed BUS cycles without bdone, so the watchdog
    // fires in the TIMEOUT_CYCLES-th BUS cycle unless bdone arrives with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if (state == ST_BUS && !bus.bdone) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ST_BUS) && !bus.bdone
                         && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = al_misaligned ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus.bdone || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_size <= 2'd0;
            lat_lo   <= 2'd0;
            lat_uns  <= 1'b0;
            addr_q   <= 32'd0;
            ttype_q  <= READ;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            cause_q  <= 4'd0;
        end else if (accept) begin
            lat_size <= req_size;
            lat_lo   <= req_addr[1:0];
            lat_uns  <= req_unsigned;
            rdata_q  <= 32'd0;
            if (al_misaligned) begin
                // bus registers untouched: a misaligned access never reaches the bus
                fault_q <= 1'b1;
                cause_q <= req_we ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
            end else begin
                addr_q  <= word_align(req_addr);
                ttype_q <= req_we ? WRITE : READ;
                wdata_q <= req_we ? al_wdata : 32'd0;
                wstrb_q <= req_we ? al_wstrb : 4'd0;
                fault_q <= 1'b0;
                cause_q <= 4'd0;
            end
        end else if (state == ST_BUS) begin
            if (bus.bdone) begin
                rdata_q <= (ttype_q == WRITE) ? 32'd0 : al_rdata;
            end else if (timeout_hit) begin
                fault_q <= 1'b1;
                cause_q <= (ttype_q == WRITE) ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                rdata_q <= 32'd0;
            end
        end
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        bus.breq   = (state == ST_BUS);
        resp_valid = (state == ST_RESP);
        resp_rdata = (state == ST_RESP) ? rdata_q : 32'd0;
        resp_fault = (state == ST_RESP) && fault_q;
        resp_cause = (state == ST_RESP) ? cause_q : 4'd0;
    end

    assign bus.addr  = addr_q;
    assign bus.ttype = ttype_q;
    assign bus.wdata = wdata_q;
    assign bus.wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for lsu. Build with LSU_BUS_TIMEOUT_EN defined to also
// exercise the bus watchdog (TIMEOUT_CYCLES overridden to 4).
// ----------------------------------------------------------------------------
module tb_lsu;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [3:0]  resp_cause;

    master_bus_if bus ();

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .resp_cause   (resp_cause)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // phase: 0 idle, 1 bus transfer in progress, 2 response cycle
    int          phase = 0;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb, exp_cause;
    logic        exp_ttype, exp_fault, exp_misal;

    int          breq_cycles, resp_pulses;
    logic [31:0] last_addr, last_wdata, last_rdata;
    logic [3:0]  last_wstrb, last_cause;
    logic        last_ttype, last_fault;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour of one access, computed from the access rules.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
        int unsigned lane, sz;
        logic [31:0] v;
        lane = addr % 4;
        sz   = (size == 2'd3) ? 2 : size;
        exp_misal = (sz == 1 && (addr % 2) != 0) || (sz == 2 && lane != 0);
        exp_addr  = addr - lane;
        exp_ttype = we;
        exp_wdata = 32'd0;
        exp_wstrb = 4'd0;
        exp_rdata = 32'd0;
        exp_fault = exp_misal;
        exp_cause = exp_misal ? (we ? 4'd6 : 4'd4) : 4'd0;
        if (we) begin
            if (sz == 0) begin
                exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
                exp_wstrb = 4'(1 << lane);
            end else if (sz == 1) begin
                exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
                exp_wstrb = 4'(3 << lane);
            end else begin
                exp_wdata = wd;
                exp_wstrb = 4'hF;
            end
        end else if (!exp_misal) begin
            v = rd >> (8 * lane);
            if (sz == 0) begin
                v = v & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (sz == 1) begin
                v = v & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            exp_rdata = v;
        end
    endtask

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_breq", bus.breq, 0);
            check("rst_req_ready", req_ready, 1);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_addr", bus.addr, 0);
            check("rst_wstrb", bus.wstrb, 0);
        end else begin
            check("breq", bus.breq, phase == 1);
            check("req_ready", req_ready, phase == 0);
            check("resp_valid", resp_valid, phase == 2);
            if (phase == 1) begin
                breq_cycles++;
                check("bus_addr", bus.addr, exp_addr);
                check("bus_ttype", bus.ttype, exp_ttype);
                check("bus_wdata", bus.wdata, exp_wdata);
                check("bus_wstrb", bus.wstrb, exp_wstrb);
                last_addr  = bus.addr;
                last_ttype = bus.ttype;
                last_wdata = bus.wdata;
                last_wstrb = bus.wstrb;
            end
            if (phase == 2) begin
                resp_pulses++;
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_fault", resp_fault, exp_fault);
                check("resp_cause", resp_cause, exp_fault ? exp_cause : 4'd0);
                last_rdata = resp_rdata;
                last_fault = resp_fault;
                last_cause = resp_cause;
            end
        end
    end

    // Called at posedge+1 with the LSU idle. bdone rises after dly BUS cycles
    // (or is held high throughout when always_done is set).
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int dly, input bit always_done);
        int k;
        breq_cycles = 0;
        resp_pulses = 0;
        last_wstrb  = 4'hx;
        model(we, size, uns, addr, wd, rd);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        bus.rdata    = rd;
        bus.bdone    = always_done;
        @(posedge clk); #1;
        req_valid = 1'b0;
        phase = exp_misal ? 2 : 1;
        k = 0;
        while (phase == 1) begin
            if (!always_done) bus.bdone = (k >= dly);
            @(posedge clk); #1;
            if (bus.bdone) begin
                phase = 2;
            end
`ifdef LSU_BUS_TIMEOUT_EN
            else if (k == TO - 1) begin
                phase = 2;
                exp_fault = 1'b1;
                exp_cause = we ? 4'd7 : 4'd5;
                exp_rdata = 32'd0;
            end
`endif
            else begin
                k++;
            end
        end
        if (!always_done) bus.bdone = 1'b0;
        @(posedge clk); #1;
        phase = 0;
        bus.bdone = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.rdata = 32'd0;
        bus.bdone = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_ttype", bus.ttype, READ);
        check("rst_wdata", bus.wdata, 0);
        check("rst_resp_cause", resp_cause, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // store word, bdone always high
        run_op(1, 2'd2, 0, 32'h0200_4000, 32'h0000_1234, 32'h0, 0, 1);
        check("sw_breq_cycles", breq_cycles, 1);
        check("sw_addr", last_addr, 32'h0200_4000);
        check("sw_wstrb", last_wstrb, 4'b1111);
        check("sw_wdata", last_wdata, 32'h0000_1234);
        check("sw_fault", last_fault, 0);
        check("sw_resp_pulses", resp_pulses, 1);

        // signed / unsigned byte loads
        run_op(0, 2'd0, 0, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
        check("lb_rdata", last_rdata, 32'hFFFF_FF80);
        check("lb_wstrb", last_wstrb, 4'd0);
        run_op(0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
        check("lbu_rdata", last_rdata, 32'h0000_0080);

        // store half replication
        run_op(1, 2'd1, 0, 32'h1002, 32'h0000_BEEF, 32'h0, 0, 0);
        check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb", last_wstrb, 4'b1100);

        // store byte at offset 1
        run_op(1, 2'd0, 0, 32'h1001, 32'h1234_56A5, 32'h0, 0, 0);
        check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        check("sb_wstrb", last_wstrb, 4'b0010);

        // signed half from upper lane
        run_op(0, 2'd1, 0, 32'h1002, 32'h0, 32'h8001_7FFF, 0, 0);
        check("lh_rdata", last_rdata, 32'hFFFF_8001);

        // load word with delayed bdone
        run_op(0, 2'd2, 0, 32'h1000, 32'h0, 32'hCAFE_F00D, 3, 0);
        check("lw_breq_cycles", breq_cycles, 4);
        check("lw_resp_pulses", resp_pulses, 1);
        check("lw_rdata", last_rdata, 32'hCAFE_F00D);

        // illegal size 3 behaves as word
        run_op(0, 2'd3, 0, 32'h1004, 32'h0, 32'h1357_9BDF, 0, 0);
        check("sz3_rdata", last_rdata, 32'h1357_9BDF);

        // misaligned accesses
        run_op(0, 2'd2, 0, 32'h1001, 32'h0, 32'h0, 0, 0);
        check("lw_mis_breq", breq_cycles, 0);
        check("lw_mis_fault", last_fault, 1);
        check("lw_mis_cause", last_cause, 4'd4);
        run_op(1, 2'd1, 0, 32'h1003, 32'h5555, 32'h0, 0, 0);
        check("sh_mis_breq", breq_cycles, 0);
        check("sh_mis_cause", last_cause, 4'd6);

        // reset during BUS with bdone held low
        model(0, 2'd2, 0, 32'h2000, 32'h0, 32'h0);
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h2000; req_valid = 1'b1;
        bus.bdone = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        phase = 1;
        @(posedge clk); #2;
        phase = 0;
        rst_n = 1'b0;
        #1;
        check("arst_breq", bus.breq, 0);
        check("arst_req_ready", req_ready, 1);
        check("arst_resp_valid", resp_valid, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        resp_pulses = 0;
        repeat (5) @(posedge clk);
        #1;
        check("arst_no_resp", resp_pulses, 0);

`ifdef LSU_BUS_TIMEOUT_EN
        run_op(1, 2'd2, 0, 32'h3000, 32'hDEAD_BEEF, 32'h0, 1000, 0);
        check("to_breq_cycles", breq_cycles, 4);
        check("to_fault", last_fault, 1);
        check("to_cause", last_cause, 4'd7);
        run_op(1, 2'd2, 0, 32'h3000, 32'hDEAD_BEEF, 32'h0, 3, 0);
        check("to_race_breq_cycles", breq_cycles, 4);
        check("to_race_fault", last_fault, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "bench timed out");
    end

endmodule
